rate_controller: RTL and testbench

Body-rate PI controller sitting directly downstream of the angle controller. It consumes the limited yaw/pitch/roll rate targets and the throttle rate from that stage, plus measured body rates from the IMU gyro. It produces per-axis rate commands for the motor mixer. One shared multiplier is time-multiplexed across roll, pitch and yaw by a sequencing FSM, using the same start/active/complete handshake as the angle stage.

---
 rtl/rate_controller_pkg.sv | 67 ++++++
 rtl/rate_controller_sat_mult.sv | 25 ++
 rtl/rate_controller.sv | 175 +++++++++++++++++
 tb/tb_rate_controller.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rate_controller_pkg.sv
// Shared constants, state/axis types and saturating Q12.4 arithmetic for rate_controller.
// RATE_CTRL_INTEGRAL_EN adds the integral-path constants.
package rate_controller_pkg;

   localparam int RATE_BIT_WIDTH = 16;
   localparam int GAIN_FRAC_BITS = 8;

   typedef logic signed [RATE_BIT_WIDTH-1:0] rate_t;

   localparam rate_t RATE_MAX = 16'sh7FFF;
   localparam rate_t RATE_MIN = 16'sh8000;
   localparam rate_t KP       = 16'sh0100;
   localparam rate_t OUT_MAX  = 16'sh0190;
   localparam rate_t OUT_MIN  = 16'shFE70;

`ifdef RATE_CTRL_INTEGRAL_EN
   localparam rate_t KI             = 16'sh0010;
   localparam rate_t INTEGRAL_LIMIT = 16'sh00C8;
   localparam rate_t THROTTLE_IDLE  = 16'sh0040;
`endif

   typedef enum logic [6:0] {
      ST_WAITING  = 7'b0000001,
      ST_ERROR    = 7'b0000010,
      ST_PTERM    = 7'b0000100,
      ST_ITERM    = 7'b0001000,
      ST_SUM      = 7'b0010000,
      ST_LIMIT    = 7'b0100000,
      ST_COMPLETE = 7'b1000000
   } state_t;

   typedef enum logic [1:0] {
      AXIS_ROLL  = 2'd0,
      AXIS_PITCH = 2'd1,
      AXIS_YAW   = 2'd2
   } axis_t;

   // A 17-bit intermediate overflowed when its two top bits disagree.
   function automatic rate_t sat_to_rate(input logic [RATE_BIT_WIDTH:0] v);
      rate_t r;
      if (v[RATE_BIT_WIDTH] != v[RATE_BIT_WIDTH-1])
         r = v[RATE_BIT_WIDTH] ? RATE_MIN : RATE_MAX;
      else
         r = v[RATE_BIT_WIDTH-1:0];
      return r;
   endfunction

   function automatic rate_t sat_add(input rate_t a, input rate_t b);
      return sat_to_rate({a[RATE_BIT_WIDTH-1], a} + {b[RATE_BIT_WIDTH-1], b});
   endfunction

   function automatic rate_t sat_sub(input rate_t a, input rate_t b);
      return sat_to_rate({a[RATE_BIT_WIDTH-1], a} - {b[RATE_BIT_WIDTH-1], b});
   endfunction

   function automatic rate_t clamp_rate(input rate_t v, input rate_t lo, input rate_t hi);
      rate_t r;
      if (v > hi)
         r = hi;
      else if (v < lo)
         r = lo;
      else
         r = v;
      return r;
   endfunction

endpackage

// File: rtl/rate_controller_sat_mult.sv
// Shared multiplier: signed Q12.4 rate times Q8.8 gain, scaled back to Q12.4 with 16-bit saturation.
module sat_mult
   import rate_controller_pkg::*;
(
   input  logic signed [RATE_BIT_WIDTH-1:0] rate,
   input  logic signed [RATE_BIT_WIDTH-1:0] gain,
   output logic signed [RATE_BIT_WIDTH-1:0] product
);

   logic signed [2*RATE_BIT_WIDTH-1:0] full_product;
   logic signed [2*RATE_BIT_WIDTH-1:0] scaled;

   assign full_product = rate * gain;
   assign scaled       = full_product >>> GAIN_FRAC_BITS;

   // In range only when every bit above the result's sign bit repeats it.
   always_comb begin
      if ((scaled[2*RATE_BIT_WIDTH-1:RATE_BIT_WIDTH-1] == '0) ||
          (scaled[2*RATE_BIT_WIDTH-1:RATE_BIT_WIDTH-1] == '1))
         product = scaled[RATE_BIT_WIDTH-1:0];
      else
         product = scaled[2*RATE_BIT_WIDTH-1] ? RATE_MIN : RATE_MAX;
   end

endmodule

// File: rtl/rate_controller.sv
// Body-rate PI controller: roll, pitch and yaw share one saturating multiplier under a sequencing FSM.
// Define RATE_CTRL_INTEGRAL_EN for full PI behaviour; left undefined the integral path is removed.
module rate_controller
   import rate_controller_pkg::*;
(
   input  logic                             us_clk,
   input  logic                             resetn,
   input  logic                             start_signal,
   input  logic signed [RATE_BIT_WIDTH-1:0] throttle_rate_in,
   input  logic signed [RATE_BIT_WIDTH-1:0] yaw_rate_target,
   input  logic signed [RATE_BIT_WIDTH-1:0] pitch_rate_target,
   input  logic signed [RATE_BIT_WIDTH-1:0] roll_rate_target,
   input  logic signed [RATE_BIT_WIDTH-1:0] yaw_rate_actual,
   input  logic signed [RATE_BIT_WIDTH-1:0] pitch_rate_actual,
   input  logic signed [RATE_BIT_WIDTH-1:0] roll_rate_actual,
   output logic signed [RATE_BIT_WIDTH-1:0] throttle_out,
   output logic signed [RATE_BIT_WIDTH-1:0] yaw_cmd_out,
   output logic signed [RATE_BIT_WIDTH-1:0] pitch_cmd_out,
   output logic signed [RATE_BIT_WIDTH-1:0] roll_cmd_out,
   output logic                             active_signal,
   output logic                             complete_signal
);

   state_t state;
   axis_t  axis;

   rate_t  target_lat [3];
   rate_t  actual_lat [3];
   rate_t  throttle_lat;

   rate_t  err_reg;
   rate_t  p_reg;
   rate_t  sum_reg;
   rate_t  stage_roll;
   rate_t  stage_pitch;

   rate_t  cur_target;
   rate_t  cur_actual;
   rate_t  cur_integ;
   rate_t  err_next;
   rate_t  mult_gain;
   rate_t  mult_out;
   rate_t  limited;

`ifdef RATE_CTRL_INTEGRAL_EN
   rate_t  integ [3];
   rate_t  integ_next;
   logic   throttle_idle;
`endif

   always_comb begin
      cur_target = target_lat[axis];
      cur_actual = actual_lat[axis];
      err_next   = sat_sub(cur_target, cur_actual);
      limited    = clamp_rate(sum_reg, OUT_MIN, OUT_MAX);
   end

`ifdef RATE_CTRL_INTEGRAL_EN
   // ITERM borrows the multiplier with the integral gain; PTERM uses KP.
   assign mult_gain     = (state == ST_ITERM) ? KI : KP;
   assign cur_integ     = integ[axis];
   assign throttle_idle = (throttle_lat < THROTTLE_IDLE);
   assign integ_next    = throttle_idle ? '0 :
                          clamp_rate(sat_add(cur_integ, mult_out), -INTEGRAL_LIMIT, INTEGRAL_LIMIT);
`else
   assign mult_gain = KP;
   assign cur_integ = '0;
`endif

   sat_mult u_sat_mult (
      .rate    (err_reg),
      .gain    (mult_gain),
      .product (mult_out)
   );

   // Results stay in staging registers until the yaw LIMIT step, so all outputs move together.
   always_ff @(posedge us_clk or negedge resetn) begin
      if (!resetn) begin
         state           <= ST_WAITING;
         axis            <= AXIS_ROLL;
         throttle_lat    <= '0;
         err_reg         <= '0;
         p_reg           <= '0;
         sum_reg         <= '0;
         stage_roll      <= '0;
         stage_pitch     <= '0;
         throttle_out    <= '0;
         yaw_cmd_out     <= '0;
         pitch_cmd_out   <= '0;
         roll_cmd_out    <= '0;
         active_signal   <= 1'b0;
         complete_signal <= 1'b0;
         for (int i = 0; i < 3; i++) begin
            target_lat[i] <= '0;
            actual_lat[i] <= '0;
`ifdef RATE_CTRL_INTEGRAL_EN
            integ[i]      <= '0;
`endif
         end
      end else begin
         complete_signal <= 1'b0;
         case (state)
            ST_WAITING: begin
               if (start_signal) begin
                  target_lat[AXIS_ROLL]  <= roll_rate_target;
                  target_lat[AXIS_PITCH] <= pitch_rate_target;
                  target_lat[AXIS_YAW]   <= yaw_rate_target;
                  actual_lat[AXIS_ROLL]  <= roll_rate_actual;
                  actual_lat[AXIS_PITCH] <= pitch_rate_actual;
                  actual_lat[AXIS_YAW]   <= yaw_rate_actual;
                  throttle_lat           <= throttle_rate_in;
                  axis                   <= AXIS_ROLL;
                  active_signal          <= 1'b1;
                  state                  <= ST_ERROR;
               end
            end
            ST_ERROR: begin
               err_reg <= err_next;
               state   <= ST_PTERM;
            end
            ST_PTERM: begin
               p_reg <= mult_out;
`ifdef RATE_CTRL_INTEGRAL_EN
               state <= ST_ITERM;
`else
               state <= ST_SUM;
`endif
            end
`ifdef RATE_CTRL_INTEGRAL_EN
            ST_ITERM: begin
               integ[axis] <= integ_next;
               state       <= ST_SUM;
            end
`endif
            ST_SUM: begin
               sum_reg <= sat_add(p_reg, cur_integ);
               state   <= ST_LIMIT;
            end
            ST_LIMIT: begin
               case (axis)
                  AXIS_ROLL: begin
                     stage_roll <= limited;
                     axis       <= AXIS_PITCH;
                     state      <= ST_ERROR;
                  end
                  AXIS_PITCH: begin
                     stage_pitch <= limited;
                     axis        <= AXIS_YAW;
                     state       <= ST_ERROR;
                  end
                  default: begin
                     roll_cmd_out    <= stage_roll;
                     pitch_cmd_out   <= stage_pitch;
                     yaw_cmd_out     <= limited;
                     throttle_out    <= throttle_lat;
                     axis            <= AXIS_ROLL;
                     active_signal   <= 1'b0;
                     complete_signal <= 1'b1;
                     state           <= ST_COMPLETE;
                  end
               endcase
            end
            ST_COMPLETE: begin
               state <= ST_WAITING;
            end
            default: begin
               active_signal <= 1'b0;
               axis          <= AXIS_ROLL;
               state         <= ST_WAITING;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rate_controller.sv
// Self-checking bench for rate_controller: vector table, handshake/timing sequences and randomized
// updates against a behavioural PI model. Expectations follow RATE_CTRL_INTEGRAL_EN.
`timescale 1ns/1ps
module tb_rate_controller;

`ifdef RATE_CTRL_INTEGRAL_EN
   localparam int LAT      = 15;
   localparam bit INTEG_ON = 1'b1;
`else
   localparam int LAT      = 12;
   localparam bit INTEG_ON = 1'b0;
`endif
   localparam int PERIOD = LAT + 2;

   logic        us_clk;
   logic        resetn;
   logic        start_signal;
   logic [15:0] throttle_rate_in;
   logic [15:0] yaw_rate_target, pitch_rate_target, roll_rate_target;
   logic [15:0] yaw_rate_actual, pitch_rate_actual, roll_rate_actual;
   logic [15:0] throttle_out, yaw_cmd_out, pitch_cmd_out, roll_cmd_out;
   logic        active_signal, complete_signal;

   int checks = 0;
   int errors = 0;

   // Behavioural model state: index 0 roll, 1 pitch, 2 yaw
   int          m_integ [3];
   logic [15:0] m_tgt [3];
   logic [15:0] m_act [3];
   logic [15:0] m_cmd [3];

   typedef struct {
      logic [15:0] thr;
      logic [15:0] rt, ra, pt, pa, yt, ya;
      logic [15:0] er, ep, ey;
   } vec_t;

   vec_t vectors [5];

   rate_controller dut (
      .us_clk            (us_clk),
      .resetn            (resetn),
      .start_signal      (start_signal),
      .throttle_rate_in  (throttle_rate_in),
      .yaw_rate_target   (yaw_rate_target),
      .pitch_rate_target (pitch_rate_target),
      .roll_rate_target  (roll_rate_target),
      .yaw_rate_actual   (yaw_rate_actual),
      .pitch_rate_actual (pitch_rate_actual),
      .roll_rate_actual  (roll_rate_actual),
      .throttle_out      (throttle_out),
      .yaw_cmd_out       (yaw_cmd_out),
      .pitch_cmd_out     (pitch_cmd_out),
      .roll_cmd_out      (roll_cmd_out),
      .active_signal     (active_signal),
      .complete_signal   (complete_signal)
   );

   initial us_clk = 1'b0;
   always #5 us_clk = ~us_clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge us_clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [15:0] thr, input logic [15:0] rt, input logic [15:0] ra,
                                input logic [15:0] pt, input logic [15:0] pa,
                                input logic [15:0] yt, input logic [15:0] ya);
      throttle_rate_in  = thr;
      roll_rate_target  = rt;
      roll_rate_actual  = ra;
      pitch_rate_target = pt;
      pitch_rate_actual = pa;
      yaw_rate_target   = yt;
      yaw_rate_actual   = ya;
   endtask

   task automatic scramble_inputs();
      applyStimulus(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                    16'($urandom), 16'($urandom), 16'($urandom));
   endtask

   function automatic int clampi(input int v, input int lo, input int hi);
      int r;
      r = v;
      if (r < lo) r = lo;
      if (r > hi) r = hi;
      return r;
   endfunction

   // PI law evaluated directly with integer arithmetic, axes in roll/pitch/yaw order
   task automatic model_update(input logic [15:0] thr);
      for (int ax = 0; ax < 3; ax++) begin
         int err, p, s;
         err = clampi(int'($signed(m_tgt[ax])) - int'($signed(m_act[ax])), -32768, 32767);
         p   = clampi((err * 256) >>> 8, -32768, 32767);
         if (!INTEG_ON || int'($signed(thr)) < 64)
            m_integ[ax] = 0;
         else
            m_integ[ax] = clampi(m_integ[ax] + ((err * 16) >>> 8), -200, 200);
         s = clampi(p + m_integ[ax], -32768, 32767);
         m_cmd[ax] = 16'(clampi(s, -400, 400));
      end
   endtask

   // One full update: start at E0, scramble inputs, expect the pulse exactly LAT edges later
   task automatic run_update(input string name, input logic [15:0] thr,
                             input logic [15:0] rt, input logic [15:0] ra,
                             input logic [15:0] pt, input logic [15:0] pa,
                             input logic [15:0] yt, input logic [15:0] ya,
                             input logic [15:0] er, input logic [15:0] ep, input logic [15:0] ey);
      int   edges;
      logic active_ok;
      applyStimulus(thr, rt, ra, pt, pa, yt, ya);
      start_signal = 1'b1;
      tick();
      start_signal = 1'b0;
      scramble_inputs();
      edges     = 0;
      active_ok = 1'b1;
      while (complete_signal !== 1'b1 && edges < 4 * LAT) begin
         if (active_signal !== 1'b1) active_ok = 1'b0;
         tick();
         edges++;
      end
      checkOutput({name, " latency"}, 16'(edges), 16'(LAT));
      checkOutput({name, " active"}, {15'b0, active_ok}, 16'h0001);
      checkOutput({name, " roll"}, roll_cmd_out, er);
      checkOutput({name, " pitch"}, pitch_cmd_out, ep);
      checkOutput({name, " yaw"}, yaw_cmd_out, ey);
      checkOutput({name, " throttle"}, throttle_out, thr);
      tick();
      checkOutput({name, " pulse_end"}, {14'b0, complete_signal, active_signal}, 16'h0000);
   endtask

   initial begin
      int          pulses;
      int          first_edge;
      int          pulse_q [$];
      int          p0, p1;
      logic [15:0] rthr;
      logic [15:0] exp_roll;

      vectors[0] = '{16'h0000, 16'h00A0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                     16'h00A0, 16'h0000, 16'h0000};
      vectors[1] = '{16'h0030, 16'h0190, 16'hFE70, 16'hFFF0, 16'h0010, 16'h0050, 16'h0060,
                     16'h0190, 16'hFFE0, 16'hFFF0};
      vectors[2] = '{16'h003F, 16'hFE70, 16'h0190, 16'h7FFF, 16'h8000, 16'h8000, 16'h7FFF,
                     16'hFE70, 16'h0190, 16'hFE70};
      vectors[3] = '{16'hFFFF, 16'h0191, 16'h0000, 16'hFE6F, 16'h0000, 16'h0123, 16'h0023,
                     16'h0190, 16'hFE70, 16'h0100};
      vectors[4] = '{16'h0000, 16'h0190, 16'h0000, 16'h0000, 16'h0190, 16'h0001, 16'h0000,
                     16'h0190, 16'hFE70, 16'h0001};

      for (int i = 0; i < 3; i++) m_integ[i] = 0;

      $display("[TB] reset");
      resetn       = 1'b0;
      start_signal = 1'b0;
      applyStimulus(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
      repeat (3) tick();
      checkOutput("reset throttle", throttle_out, 16'h0000);
      checkOutput("reset roll", roll_cmd_out, 16'h0000);
      checkOutput("reset pitch", pitch_cmd_out, 16'h0000);
      checkOutput("reset yaw", yaw_cmd_out, 16'h0000);
      checkOutput("reset flags", {14'b0, complete_signal, active_signal}, 16'h0000);
      resetn = 1'b1;
      tick();

      $display("[TB] vector table (throttle below idle)");
      for (int i = 0; i < 5; i++)
         run_update($sformatf("vec%0d", i), vectors[i].thr, vectors[i].rt, vectors[i].ra,
                    vectors[i].pt, vectors[i].pa, vectors[i].yt, vectors[i].ya,
                    vectors[i].er, vectors[i].ep, vectors[i].ey);

      $display("[TB] nominal and integrator build-up");
      for (int k = 1; k <= 22; k++) begin
         exp_roll = INTEG_ON ? 16'(160 + ((10 * k > 200) ? 200 : 10 * k)) : 16'h00A0;
         run_update($sformatf("integ%0d", k), 16'h0140, 16'h00A0, 16'h0000, 16'h0000, 16'h0000,
                    16'h0000, 16'h0000, exp_roll, 16'h0000, 16'h0000);
      end
      run_update("idle_clear", 16'h0000, 16'h00A0, 16'h0000, 16'h0000, 16'h0000,
                 16'h0000, 16'h0000, 16'h00A0, 16'h0000, 16'h0000);

      $display("[TB] output saturation");
      run_update("sat_pos", 16'h0140, 16'h0190, 16'hFE70, 16'h0000, 16'h0000,
                 16'h0000, 16'h0000, 16'h0190, 16'h0000, 16'h0000);
      run_update("sat_neg", 16'h0140, 16'hFE70, 16'h0190, 16'h0000, 16'h0000,
                 16'h0000, 16'h0000, 16'hFE70, 16'h0000, 16'h0000);

      $display("[TB] start while busy");
      applyStimulus(16'h0000, 16'h00A0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
      start_signal = 1'b1;
      tick();
      start_signal = 1'b0;
      pulses     = 0;
      first_edge = -1;
      for (int e = 1; e <= 2 * LAT + 8; e++) begin
         start_signal = (e == 3) || (e == LAT) || (e == LAT + 1);
         tick();
         start_signal = 1'b0;
         if (complete_signal === 1'b1) begin
            pulses++;
            if (first_edge < 0) first_edge = e;
         end
      end
      checkOutput("busy pulses", 16'(pulses), 16'h0001);
      checkOutput("busy pulse edge", 16'(first_edge), 16'(LAT));
      checkOutput("busy roll", roll_cmd_out, 16'h00A0);

      $display("[TB] start held high");
      applyStimulus(16'h0020, 16'h00A0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
      start_signal = 1'b1;
      tick();
      for (int e = 1; e <= 3 * LAT + 5; e++) begin
         tick();
         if (complete_signal === 1'b1) pulse_q.push_back(e);
      end
      start_signal = 1'b0;
      tick();
      tick();
      p0 = (pulse_q.size() > 0) ? pulse_q[0] : -1;
      p1 = (pulse_q.size() > 1) ? pulse_q[1] : -1;
      checkOutput("held pulses", 16'(pulse_q.size()), 16'h0003);
      checkOutput("held first edge", 16'(p0), 16'(LAT));
      checkOutput("held period", 16'(p1 - p0), 16'(PERIOD));
      checkOutput("held roll", roll_cmd_out, 16'h00A0);
      checkOutput("held throttle", throttle_out, 16'h0020);

      $display("[TB] reset mid-update");
      applyStimulus(16'h0140, 16'h0050, 16'h0000, 16'h0030, 16'h0000, 16'h0000, 16'h0000);
      start_signal = 1'b1;
      tick();
      start_signal = 1'b0;
      repeat (5) tick();
      resetn = 1'b0;
      #1;
      checkOutput("midrst throttle", throttle_out, 16'h0000);
      checkOutput("midrst roll", roll_cmd_out, 16'h0000);
      checkOutput("midrst flags", {14'b0, complete_signal, active_signal}, 16'h0000);
      tick();
      resetn = 1'b1;
      for (int i = 0; i < 3; i++) m_integ[i] = 0;
      pulses = 0;
      repeat (LAT + 5) begin
         tick();
         if (complete_signal === 1'b1) pulses++;
      end
      checkOutput("midrst no pulse", 16'(pulses), 16'h0000);
      checkOutput("midrst roll held", roll_cmd_out, 16'h0000);

      m_tgt[0] = 16'h00A0; m_act[0] = 16'h0000;
      m_tgt[1] = 16'h0000; m_act[1] = 16'h0000;
      m_tgt[2] = 16'h0000; m_act[2] = 16'h0000;
      model_update(16'h0140);
      run_update("post_reset", 16'h0140, m_tgt[0], m_act[0], m_tgt[1], m_act[1], m_tgt[2], m_act[2],
                 m_cmd[0], m_cmd[1], m_cmd[2]);

      $display("[TB] randomized updates");
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 4))
            0:       rthr = 16'h003F;
            1:       rthr = 16'h0040;
            2:       rthr = 16'($urandom);
            default: rthr = 16'($urandom_range(16'h0040, 16'h0200));
         endcase
         for (int ax = 0; ax < 3; ax++) begin
            case ($urandom_range(0, 3))
               0:       m_tgt[ax] = 16'($urandom);
               1:       m_tgt[ax] = 16'(int'($urandom_range(0, 1600)) - 800);
               default: m_tgt[ax] = 16'(int'($urandom_range(0, 400)) - 200);
            endcase
            case ($urandom_range(0, 3))
               0:       m_act[ax] = 16'($urandom);
               default: m_act[ax] = 16'(int'($urandom_range(0, 400)) - 200);
            endcase
         end
         model_update(rthr);
         run_update($sformatf("rand%0d", i), rthr, m_tgt[0], m_act[0], m_tgt[1], m_act[1],
                    m_tgt[2], m_act[2], m_cmd[0], m_cmd[1], m_cmd[2]);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
